// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
//   byte_valid/byte_data/byte_ready : producer -> loader byte handshake
//   mem_we/mem_addr/mem_wdata       : loader -> instruction memory write port
// master = byte producer / memory side, slave = the loader.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Run-time program loader for the instruction memory.
// Assembles 4 streamed bytes into one 32-bit instruction word and writes the
// words to consecutive word addresses from word 0, holding the CPU meanwhile.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request a load of word_count words (sampled in IDLE)
//   abort       : cancel the load in progress
//   word_count  : number of words, 0 .. 2^ADDR_WIDTH valid
//   bus         : byte handshake in, memory write port out
//   cpu_hold    : CPU stalled while loading/writing
//   busy        : loader not idle
//   done        : one-cycle pulse after the final write
//   err         : sticky, set by a start with an oversized word_count
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   word_count,
  imem_loader_if.slave          bus,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t              state;
  logic [1:0]          byte_idx;
  logic [ADDR_WIDTH:0] word_idx;
  logic [ADDR_WIDTH:0] count;
  logic [ADDR_WIDTH:0] word_idx_nxt;
  logic [31:0]         asm_word;
  logic [31:0]         merged;
  logic [1:0]          lane;

  // Assembly register with the incoming byte dropped into its lane.
  always_comb begin
    lane   = BIG_ENDIAN ? (2'd3 - byte_idx) : byte_idx;
    merged = asm_word;
    merged[{lane, 3'b000} +: 8] = bus.byte_data;
  end

  assign word_idx_nxt = word_idx + CW'(1);

  // Control FSM; every output is registered from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      byte_idx       <= 2'd0;
      word_idx       <= '0;
      count          <= '0;
      asm_word       <= 32'd0;
      bus.byte_ready <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= 32'd0;
      bus.mem_wdata  <= 32'd0;
      cpu_hold       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (word_count == '0) begin
              state <= DONE;
              busy  <= 1'b1;
              done  <= 1'b1;
            end else if (word_count <= DEPTH) begin
              state          <= LOAD;
              count          <= word_count;
              byte_idx       <= 2'd0;
              word_idx       <= '0;
              err            <= 1'b0;
              bus.byte_ready <= 1'b1;
              cpu_hold       <= 1'b1;
              busy           <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end

        LOAD: begin
          // Abort wins over a byte presented in the same cycle.
          if (abort) begin
            state          <= IDLE;
            byte_idx       <= 2'd0;
            bus.byte_ready <= 1'b0;
            cpu_hold       <= 1'b0;
            busy           <= 1'b0;
          end else if (bus.byte_valid) begin
            asm_word <= merged;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state          <= WRITE;
              bus.byte_ready <= 1'b0;
              bus.mem_we     <= 1'b1;
              bus.mem_addr   <= 32'(word_idx) << 2;
              bus.mem_wdata  <= merged;
            end
          end
        end

        WRITE: begin
          word_idx <= word_idx_nxt;
          if (abort) begin
            state    <= IDLE;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
          end else if (word_idx_nxt == count) begin
            state    <= DONE;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end else begin
            state          <= LOAD;
            bus.byte_ready <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: big- and little-endian instances share one stimulus
// and are checked every cycle against a byte-queue model of the loader.
module tb_imem_loader;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW:0]   word_count = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'd0;
  logic          hold_b, busy_b, done_b, err_b;
  logic          hold_l, busy_l, done_l, err_l;

  always #5 clk = ~clk;

  imem_loader_if ifb ();
  imem_loader_if ifl ();
  assign ifb.byte_valid = byte_valid;
  assign ifb.byte_data  = byte_data;
  assign ifl.byte_valid = byte_valid;
  assign ifl.byte_data  = byte_data;

  imem_loader #(.ADDR_WIDTH(AW), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .word_count(word_count), .bus(ifb.slave),
    .cpu_hold(hold_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  imem_loader #(.ADDR_WIDTH(AW), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .word_count(word_count), .bus(ifl.slave),
    .cpu_hold(hold_l), .busy(busy_l), .done(done_l), .err(err_l)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 collecting bytes, 2 write cycle, 3 done cycle
  int          m_mode = 0;
  logic [7:0]  got[$];
  int          m_cnt = 0;
  int          m_widx = 0;
  logic        m_err = 1'b0;
  logic [31:0] m_be = 32'd0;
  logic [31:0] m_le = 32'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; got.delete(); m_cnt = 0; m_widx = 0; m_err = 1'b0;
    end else begin
      case (m_mode)
        0: if (start) begin
          if (int'(word_count) == 0) m_mode = 3;
          else if (int'(word_count) <= DEPTH) begin
            m_cnt = int'(word_count); m_widx = 0; got.delete(); m_err = 1'b0; m_mode = 1;
          end else m_err = 1'b1;
        end
        1: if (abort) begin
          got.delete(); m_mode = 0;
        end else if (byte_valid) begin
          got.push_back(byte_data);
          if (got.size() == 4) begin
            m_be = {got[0], got[1], got[2], got[3]};
            m_le = {got[3], got[2], got[1], got[0]};
            m_mode = 2;
          end
        end
        2: begin
          m_widx++; got.delete();
          if (abort) m_mode = 0;
          else if (m_widx == m_cnt) m_mode = 3;
          else m_mode = 1;
        end
        default: m_mode = 0;
      endcase
    end
  end

  // ---------------- compare process ----------------
  logic [31:0] wlog_addr[$];
  logic [31:0] wlog_be[$];
  logic [31:0] wlog_le[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      logic e_ready, e_hold, e_busy, e_done, e_we;
      e_ready = (m_mode == 1);
      e_hold  = (m_mode == 1) || (m_mode == 2);
      e_busy  = (m_mode != 0);
      e_done  = (m_mode == 3);
      e_we    = (m_mode == 2);
      chk("ready_be", 32'(ifb.byte_ready), 32'(e_ready));
      chk("ready_le", 32'(ifl.byte_ready), 32'(e_ready));
      chk("hold_be",  32'(hold_b), 32'(e_hold));
      chk("hold_le",  32'(hold_l), 32'(e_hold));
      chk("busy_be",  32'(busy_b), 32'(e_busy));
      chk("busy_le",  32'(busy_l), 32'(e_busy));
      chk("done_be",  32'(done_b), 32'(e_done));
      chk("done_le",  32'(done_l), 32'(e_done));
      chk("err_be",   32'(err_b),  32'(m_err));
      chk("err_le",   32'(err_l),  32'(m_err));
      chk("we_be",    32'(ifb.mem_we), 32'(e_we));
      chk("we_le",    32'(ifl.mem_we), 32'(e_we));
      if (e_we) begin
        chk("addr_be",  ifb.mem_addr, 32'(m_widx * 4));
        chk("addr_le",  ifl.mem_addr, 32'(m_widx * 4));
        chk("wdata_be", ifb.mem_wdata, m_be);
        chk("wdata_le", ifl.mem_wdata, m_le);
      end
      if (ifb.mem_we) begin
        wlog_addr.push_back(ifb.mem_addr);
        wlog_be.push_back(ifb.mem_wdata);
        wlog_le.push_back(ifl.mem_wdata);
      end
      if (done_b) done_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] src[$];

  task automatic clear_logs();
    wlog_addr.delete(); wlog_be.delete(); wlog_le.delete(); done_cnt = 0;
  endtask

  // gap: 0 none, 1 valid on every third cycle, 2 random.
  // amode: 0 none, 1 abort once aval bytes sent, 2 abort during write #aval,
  //        3 stop driving once aval bytes sent (returns with the loader busy).
  task automatic run(input int wc, input int gap, input int amode, input int aval, input bit noise);
    int sent = 0;
    int cyc = 0;
    int writes_seen = 0;
    bit v;
    @(negedge clk);
    start = 1'b1; word_count = (AW+1)'(wc);
    while (1) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; byte_valid = 1'b0; cyc++;
      if (!busy_b) break;
      if (cyc > 20000) begin
        chk("load_timeout", 32'(busy_b), 32'd0);
        break;
      end
      if (noise && $urandom_range(0, 5) == 0) begin
        start = 1'b1; word_count = (AW+1)'($urandom_range(0, 2047));
      end
      if (ifb.mem_we) writes_seen++;
      if (amode == 3 && sent == aval) begin
        return;
      end else if (amode == 1 && sent == aval && ifb.byte_ready) begin
        abort = 1'b1; byte_valid = 1'b1;
        byte_data = (sent < src.size()) ? src[sent] : 8'hEE;
      end else if (amode == 2 && ifb.mem_we && writes_seen == aval) begin
        abort = 1'b1;
      end else if (sent < src.size()) begin
        v = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 3 == 1) : 1'($urandom_range(0, 1));
        byte_valid = v; byte_data = src[sent];
        if (v && ifb.byte_ready) sent++;
      end else begin
        byte_data = 8'($urandom);
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    int wc, amode, aval;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_b), 32'd0);
    chk("rst_hold", 32'(hold_b), 32'd0);
    chk("rst_ready", 32'(ifb.byte_ready), 32'd0);
    chk("rst_we", 32'(ifb.mem_we), 32'd0);
    chk("rst_wdata", ifb.mem_wdata, 32'd0);
    chk("rst_err", 32'(err_b), 32'd0);
    rst_n = 1'b1;

    // Two words, gap-free and with a 1,0,0 valid pattern.
    for (int g = 0; g < 2; g++) begin
      src = {8'h3C, 8'h01, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00};
      clear_logs();
      run(2, g, 0, 0, 1'b0);
      chk("two_nwr", 32'(wlog_addr.size()), 32'd2);
      chk("two_addr0", wlog_addr[0], 32'h0);
      chk("two_be0", wlog_be[0], 32'h3C011234);
      chk("two_le0", wlog_le[0], 32'h3412013C);
      chk("two_addr1", wlog_addr[1], 32'h4);
      chk("two_be1", wlog_be[1], 32'h0);
      chk("two_done", 32'(done_cnt), 32'd1);
    end

    // Full depth with an incrementing word pattern.
    src.delete();
    for (int i = 0; i < DEPTH; i++) begin
      w = 32'hA500_0000 + 32'(i);
      src.push_back(w[31:24]); src.push_back(w[23:16]);
      src.push_back(w[15:8]);  src.push_back(w[7:0]);
    end
    clear_logs();
    run(DEPTH, 0, 0, 0, 1'b0);
    chk("full_nwr", 32'(wlog_addr.size()), 32'd1024);
    chk("full_last_addr", wlog_addr[wlog_addr.size()-1], 32'hFFC);
    chk("full_last_data", wlog_be[wlog_be.size()-1], 32'hA50003FF);
    chk("full_done", 32'(done_cnt), 32'd1);

    // Oversized count.
    src.delete();
    clear_logs();
    run(DEPTH + 1, 0, 0, 0, 1'b0);
    chk("over_err", 32'(err_b), 32'd1);
    chk("over_busy", 32'(busy_b), 32'd0);
    chk("over_nwr", 32'(wlog_addr.size()), 32'd0);

    // Abort after 6 bytes of a 3-word load, then reload from word 0.
    src.delete();
    for (int i = 0; i < 12; i++) src.push_back(8'(8'h11 * (i + 1)));
    clear_logs();
    run(3, 0, 1, 6, 1'b0);
    chk("abort_nwr", 32'(wlog_addr.size()), 32'd1);
    chk("abort_addr0", wlog_addr[0], 32'h0);
    chk("abort_done", 32'(done_cnt), 32'd0);
    chk("abort_busy", 32'(busy_b), 32'd0);
    src = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    clear_logs();
    run(1, 0, 0, 0, 1'b0);
    chk("reload_addr", wlog_addr[0], 32'h0);
    chk("reload_data", wlog_be[0], 32'hDEADBEEF);

    // Abort coinciding with the second write cycle: that write still lands.
    src.delete();
    for (int i = 0; i < 12; i++) src.push_back(8'($urandom));
    clear_logs();
    run(3, 0, 2, 2, 1'b0);
    chk("abortw_nwr", 32'(wlog_addr.size()), 32'd2);
    chk("abortw_done", 32'(done_cnt), 32'd0);

    // Asynchronous reset in the middle of the second word.
    src.delete();
    for (int i = 0; i < 12; i++) src.push_back(8'(8'hA5 - i));
    clear_logs();
    run(3, 0, 3, 6, 1'b0);
    chk("prerst_busy", 32'(busy_b), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_b), 32'd0);
    chk("arst_hold", 32'(hold_b), 32'd0);
    chk("arst_ready", 32'(ifb.byte_ready), 32'd0);
    chk("arst_we", 32'(ifb.mem_we), 32'd0);
    chk("arst_addr", ifb.mem_addr, 32'd0);
    chk("arst_wdata", ifb.mem_wdata, 32'd0);
    chk("arst_wdata_le", ifl.mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    src.delete();
    clear_logs();
    run(0, 0, 0, 0, 1'b0);
    chk("zero_done", 32'(done_cnt), 32'd1);
    chk("zero_nwr", 32'(wlog_addr.size()), 32'd0);

    // Randomized loads with gaps, aborts, invalid starts and start noise.
    for (int t = 0; t < 40; t++) begin
      src.delete();
      if ($urandom_range(0, 7) == 0) begin
        run($urandom_range(DEPTH + 1, 2047), 0, 0, 0, 1'b0);
      end else begin
        wc = $urandom_range(1, 6);
        for (int i = 0; i < 4 * wc; i++) src.push_back(8'($urandom));
        amode = 0; aval = 0;
        case ($urandom_range(0, 3))
          1: begin amode = 1; aval = $urandom_range(0, 4 * wc - 1); end
          2: begin amode = 2; aval = $urandom_range(1, wc); end
          default: ;
        endcase
        run(wc, $urandom_range(0, 2), amode, aval, 1'b1);
      end
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
